// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus among N_UNITS functional units.
// Each unit parks one result in a holding slot through a valid/ready
// handshake. A round-robin arbiter picks one occupied slot per cycle and
// broadcasts it on the registered cdb_* outputs for exactly one cycle.
module cdb_arbiter #(
    parameter int N_UNITS = 2,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 4,
    parameter int REG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_UNITS-1:0]         req_valid,
    input  logic [N_UNITS*DATA_W-1:0]  req_data,
    input  logic [N_UNITS*TAG_W-1:0]   req_src,
    input  logic [N_UNITS*REG_W-1:0]   req_reg,
    output logic [N_UNITS-1:0]         req_ready,
    output logic                       cdb_valid,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [TAG_W-1:0]           cdb_src,
    output logic [REG_W-1:0]           cdb_reg,
    output logic [2:0]                 cdb_unit,
    output logic [3:0]                 pending
);

    logic [N_UNITS-1:0] holdVld;
    logic [N_UNITS-1:0] holdVldNext;
    logic [N_UNITS-1:0] grant;
    logic [N_UNITS-1:0] accept;
    logic [DATA_W-1:0]  holdData [N_UNITS];
    logic [TAG_W-1:0]   holdSrc  [N_UNITS];
    logic [REG_W-1:0]   holdReg  [N_UNITS];
    logic [2:0]         lastPtr;
    logic [2:0]         winner;
    logic               anyGrant;
    logic [DATA_W-1:0]  winData;
    logic [TAG_W-1:0]   winSrc;
    logic [REG_W-1:0]   winReg;
    logic [3:0]         pendingNext;

    // Round-robin pick: first occupied slot after the last winner.
    always_comb begin
        grant    = '0;
        winner   = '0;
        anyGrant = 1'b0;
        for (int k = 1; k <= N_UNITS; k++) begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (!anyGrant && holdVld[i] && (i == (int'(lastPtr) + k) % N_UNITS)) begin
                    anyGrant = 1'b1;
                    grant[i] = 1'b1;
                    winner   = 3'(i);
                end
            end
        end
    end

    // Select the granted slot's payload for the broadcast register.
    always_comb begin
        winData = '0;
        winSrc  = '0;
        winReg  = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (grant[i]) begin
                winData = holdData[i];
                winSrc  = holdSrc[i];
                winReg  = holdReg[i];
            end
        end
    end

    // A slot is free when empty or when it is being drained this very cycle.
    assign req_ready   = ~holdVld | grant;
    assign accept      = req_valid & req_ready;
    assign holdVldNext = accept | (holdVld & ~grant);

    // Occupancy after this edge's accepts and grant, registered as pending.
    always_comb begin
        pendingNext = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            pendingNext = pendingNext + {3'b000, holdVldNext[i]};
        end
    end

    // Control state and broadcast outputs; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdVld   <= '0;
            pending   <= '0;
            lastPtr   <= 3'(N_UNITS - 1);
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            cdb_reg   <= '0;
            cdb_unit  <= '0;
        end else begin
            holdVld   <= holdVldNext;
            pending   <= pendingNext;
            cdb_valid <= anyGrant;
            if (anyGrant) begin
                lastPtr  <= winner;
                cdb_unit <= winner;
                cdb_data <= winData;
                cdb_src  <= winSrc;
                cdb_reg  <= winReg;
            end
        end
    end

    // Slot payload loads on accept; its validity lives in holdVld.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (accept[i]) begin
                holdData[i] <= req_data[i*DATA_W +: DATA_W];
                holdSrc[i]  <= req_src[i*TAG_W +: TAG_W];
                holdReg[i]  <= req_reg[i*REG_W +: REG_W];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors for the two-unit CDB arbiter plus
// hand-written sequences for saturation fairness and mid-cycle reset.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [7:0]  req_src;
    logic [7:0]  req_reg;
    logic [1:0]  req_ready;
    logic        cdb_valid;
    logic [15:0] cdb_data;
    logic [3:0]  cdb_src;
    logic [3:0]  cdb_reg;
    logic [2:0]  cdb_unit;
    logic [3:0]  pending;

    int total;
    int bad;

    cdb_arbiter #(.N_UNITS(2), .DATA_W(16), .TAG_W(4), .REG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_src(req_src), .req_reg(req_reg),
        .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_src(cdb_src), .cdb_reg(cdb_reg),
        .cdb_unit(cdb_unit), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tr fields pack {src, reg}
    typedef struct {
        logic [1:0]  v;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [7:0]  tr0;
        logic [7:0]  tr1;
        logic [1:0]  rdy;
        logic        cv;
        logic [2:0]  u;
        logic [15:0] d;
        logic [7:0]  tr;
        logic [3:0]  pend;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [7:0] tr0, input logic [7:0] tr1);
        req_valid = v;
        req_data  = {d1, d0};
        req_src   = {tr1[7:4], tr0[7:4]};
        req_reg   = {tr1[3:0], tr0[3:0]};
    endtask

    int          k0, k1, nb0, nb1;
    logic [1:0]  rdySeen;
    logic [2:0]  nextU;
    logic [15:0] expD;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 8'h0, 8'h0);

        //            v      d0        d1        tr0    tr1    rdy    cv    u     d         tr     pend
        tbl[0]  = '{2'b01, 16'h1234, 16'h0000, 8'h15, 8'h00, 2'b11, 1'b0, 3'd0, 16'h0000, 8'h00, 4'd1};
        tbl[1]  = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b1, 3'd0, 16'h1234, 8'h15, 4'd0};
        tbl[2]  = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b0, 3'd0, 16'h0000, 8'h00, 4'd0};
        tbl[3]  = '{2'b10, 16'h0000, 16'hC0DE, 8'h00, 8'h47, 2'b11, 1'b0, 3'd0, 16'h0000, 8'h00, 4'd1};
        tbl[4]  = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b1, 3'd1, 16'hC0DE, 8'h47, 4'd0};
        tbl[5]  = '{2'b11, 16'hA000, 16'hB001, 8'h21, 8'h32, 2'b11, 1'b0, 3'd0, 16'h0000, 8'h00, 4'd2};
        tbl[6]  = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b1, 3'd0, 16'hA000, 8'h21, 4'd1};
        tbl[7]  = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b1, 3'd1, 16'hB001, 8'h32, 4'd0};
        tbl[8]  = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b0, 3'd0, 16'h0000, 8'h00, 4'd0};
        tbl[9]  = '{2'b11, 16'h1111, 16'h2222, 8'h11, 8'h22, 2'b11, 1'b0, 3'd0, 16'h0000, 8'h00, 4'd2};
        tbl[10] = '{2'b10, 16'h0000, 16'h3333, 8'h00, 8'h33, 2'b01, 1'b1, 3'd0, 16'h1111, 8'h11, 4'd1};
        tbl[11] = '{2'b10, 16'h0000, 16'h3333, 8'h00, 8'h33, 2'b11, 1'b1, 3'd1, 16'h2222, 8'h22, 4'd1};
        tbl[12] = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b1, 3'd1, 16'h3333, 8'h33, 4'd0};
        tbl[13] = '{2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b11, 1'b0, 3'd0, 16'h0000, 8'h00, 4'd0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_cdb_data", 32'(cdb_data), 32'd0);
        chk("rst_cdb_unit", 32'(cdb_unit), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd3);
        rst_n = 1'b1;

        // directed table: single request, idle gap, simultaneous, backpressure
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].tr0, tbl[i].tr1);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cdb_valid", i), 32'(cdb_valid), 32'(tbl[i].cv));
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
            if (tbl[i].cv) begin
                chk($sformatf("vec%0d_cdb_unit", i), 32'(cdb_unit), 32'(tbl[i].u));
                chk($sformatf("vec%0d_cdb_data", i), 32'(cdb_data), 32'(tbl[i].d));
                chk($sformatf("vec%0d_cdb_srcreg", i), 32'({cdb_src, cdb_reg}), 32'(tbl[i].tr));
            end
        end

        // saturation: both units always valid, data advances only on handshake
        k0 = 0; k1 = 0; nb0 = 0; nb1 = 0;
        nextU = 3'd0;
        for (int e = 0; e < 11; e++) begin
            @(negedge clk);
            drive(2'b11, 16'h0A00 + 16'(k0), 16'h0B00 + 16'(k1), 8'h12, 8'h34);
            #1;
            rdySeen = req_ready;
            @(posedge clk);
            #1;
            if (rdySeen[0]) k0++;
            if (rdySeen[1]) k1++;
            chk($sformatf("sat%0d_cdb_valid", e), 32'(cdb_valid), (e == 0) ? 32'd0 : 32'd1);
            if (e != 0) begin
                chk($sformatf("sat%0d_cdb_unit", e), 32'(cdb_unit), 32'(nextU));
                expD = (nextU == 3'd0) ? 16'h0A00 + 16'(nb0) : 16'h0B00 + 16'(nb1);
                chk($sformatf("sat%0d_cdb_data", e), 32'(cdb_data), 32'(expD));
                if (cdb_unit == 3'd0) nb0++;
                else nb1++;
                nextU = (nextU == 3'd0) ? 3'd1 : 3'd0;
            end
        end
        chk("sat_grants_u0", nb0, 5);
        chk("sat_grants_u1", nb1, 5);

        // drain
        @(negedge clk);
        drive(2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_pending", 32'(pending), 32'd0);
        chk("drain_cdb_valid", 32'(cdb_valid), 32'd0);

        // async reset mid-operation with two results held
        @(negedge clk);
        drive(2'b11, 16'hDEAD, 16'hBEEF, 8'h56, 8'h78);
        @(posedge clk);
        #1;
        chk("prerst_pending_a", 32'(pending), 32'd2);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("prerst_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("prerst_pending_b", 32'(pending), 32'd2);
        #2;
        rst_n = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
        #1;
        chk("midrst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("midrst_cdb_data", 32'(cdb_data), 32'd0);
        chk("midrst_cdb_srcreg", 32'({cdb_src, cdb_reg}), 32'd0);
        chk("midrst_cdb_unit", 32'(cdb_unit), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d_cdb_valid", e), 32'(cdb_valid), 32'd0);
        end

        // first new simultaneous requests after reset: unit 0 first
        @(negedge clk);
        drive(2'b11, 16'h5A5A, 16'h6B6B, 8'h9A, 8'hBC);
        @(posedge clk);
        #1;
        chk("new_pending", 32'(pending), 32'd2);
        @(negedge clk);
        drive(2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
        @(posedge clk);
        #1;
        chk("new1_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("new1_cdb_unit", 32'(cdb_unit), 32'd0);
        chk("new1_cdb_data", 32'(cdb_data), 32'h5A5A);
        chk("new1_cdb_srcreg", 32'({cdb_src, cdb_reg}), 32'h9A);
        @(posedge clk);
        #1;
        chk("new2_cdb_unit", 32'(cdb_unit), 32'd1);
        chk("new2_cdb_data", 32'(cdb_data), 32'h6B6B);
        chk("new2_pending", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        chk("new3_cdb_valid", 32'(cdb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among N functional units (adder/jeq unit, loader, future units); one result is broadcast per cycle.
- Each unit hands its result to the arbiter over a valid/ready handshake. The result waits in a per-unit one-entry holding slot until it wins round-robin arbitration.
- The arbiter then drives it onto the registered CDB outputs, which feed register writeback and reservation-station tag matching.

Parameters:
- N_UNITS, 2, number of requesting functional units (2..8).
- DATA_W, 16, result value width.
- TAG_W, 4, producer tag width (reservation-station id).
- REG_W, 4, destination register index width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_UNITS  unit i has a result this cycle.
- req_data  in  N_UNITS*DATA_W  result values; unit i in slice [i*DATA_W +: DATA_W].
- req_src  in  N_UNITS*TAG_W  producer tags, packed the same way.
- req_reg  in  N_UNITS*REG_W  destination registers, packed the same way.
- req_ready  out  N_UNITS  unit i's slot can accept this cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  TAG_W  broadcast producer tag.
- cdb_reg  out  REG_W  broadcast destination register.
- cdb_unit  out  3  index of the unit that owns the current broadcast.
- pending  out  4  number of occupied holding slots.

Behaviour:
- Reset (async, rst_n=0):
  - All holding slots empty.
  - cdb_valid=0; cdb_data, cdb_src, cdb_reg and cdb_unit = 0.
  - pending=0.
  - Round-robin pointer last=N_UNITS-1, so unit 0 has first priority.
  - Reset asserted mid-operation discards all held results. No partial broadcast survives.
- Holding slot i: hold_v, hold_data, hold_src, hold_reg.
- req_ready[i] is combinational: ready = !hold_v[i] || grant[i]. A slot being granted this cycle may be refilled in the same cycle.
- Accept: req_valid[i] && req_ready[i] at a rising edge loads the slot and sets hold_v[i]=1.
- req_valid without ready: the unit must hold its data stable. The arbiter drops nothing.
- Arbitration (combinational, every cycle):
  - The candidate set is all slots with hold_v=1.
  - Winner is the first candidate scanning last+1, last+2, … modulo N_UNITS.
  - At most one grant per cycle.
- On a rising edge with a grant:
  - cdb_* <= winner slot contents; cdb_valid <= 1; cdb_unit <= winner.
  - last <= winner; winner's hold_v cleared, unless it is refilled by a simultaneous accept.
- On a rising edge without a grant: cdb_valid <= 0. cdb_data/src/reg hold their old values and are don't-care for consumers.
- Each broadcast lasts exactly one cycle, and no result is broadcast twice.
- Latency: a result accepted at edge k is on the CDB in the cycle after edge k+1 at the earliest (2 cycles from req_valid to cdb_valid).
- Throughput: one result per cycle sustained. Each unit is guaranteed a grant within N_UNITS cycles of its slot filling (no starvation).
- pending:
  - Registered count of hold_v bits after the edge's accepts and grant.
  - Range 0..N_UNITS.
  - Increments and decrements in the same cycle net out.
- No internal priority to any unit type. Tag matching and jeq suppression are the consumers' responsibility.
- Unit indices ≥ N_UNITS never appear on cdb_unit.

Test Plan:
- Reset, then a single request: unit 0 gives data=0x1234, src=1, reg=5 at edge 1 → cdb_valid=1 with those values for exactly the cycle after edge 2; req_ready[0]=1 throughout.
- Simultaneous requests: units 0 and 1 both valid at edge 1 → unit 0 broadcasts after edge 2 and unit 1 after edge 3; last=1; pending goes 2→1→0.
- Fairness under saturation: both units hold req_valid=1 continuously for 10 cycles → cdb_unit alternates 0,1,0,1… and each unit is granted 5 times.
- Backpressure: unit 1 slot full and not granted (unit 0 wins) while unit 1 presents a new result → req_ready[1]=0. Next cycle unit 1 is granted, ready=1, and the new result is accepted at that same edge; no value lost or duplicated.
- Async reset mid-operation: drop rst_n between edges with pending=2 → outputs clear immediately. After release the old results never appear, and the first new request from unit 0 wins.
- Idle gap: one broadcast followed by no requests → cdb_valid deasserts the next cycle and pending=0.
